pipe_stage_reg: RTL

//  Parametrised pipeline-stage register with valid/ready handshake, optional skid buffer and synchronous flush.

---
 rtl/npc_pipe_pkg.sv | 24 ++
 rtl/pipe_stage_ctrl.sv | 125 ++++++++++++
 rtl/pipe_stage_reg.sv | 86 ++++++++
 3 files changed

// File: rtl/npc_pipe_pkg.sv
// Shared definitions for the npc pipeline-stage registers.
//
// Contents:
//   pipe_state_e  occupancy state of a stage (EMPTY / BUSY / FULL)
//   occ_of()      maps a state to the number of held entries
package npc_pipe_pkg;

  // EMPTY holds nothing, BUSY holds the main entry, FULL holds main + skid.
  // Encoding 2'd3 is unused and is treated as EMPTY wherever it is decoded.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  function automatic logic [1:0] occ_of(input pipe_state_e st);
    case (st)
      ST_BUSY: occ_of = 2'd1;
      ST_FULL: occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_ctrl.sv
// Control half of a pipeline-stage register: occupancy state machine,
// handshake outputs and load enables for the payload registers kept in
// the parent.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   flush           squash all held entries
//   in_valid        upstream offers a payload
//   in_ready        stage can take a payload this cycle
//   out_valid       main entry is valid
//   out_ready       downstream takes the main entry this cycle
//   occ             entries held (0..2)
//   load_main       write the main payload register this cycle
//   main_from_skid  main register is refilled from the skid register
//   load_skid       write the skid payload register this cycle
module pipe_stage_ctrl
  import npc_pipe_pkg::*;
#(
  parameter int unsigned SKID = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] occ,
  output logic       load_main,
  output logic       main_from_skid,
  output logic       load_skid
);

  pipe_state_e state_q;
  pipe_state_e state_d;
  logic        acc;
  logic        deq;

  assign out_valid = (state_q == ST_BUSY) || (state_q == ST_FULL);
  assign occ       = occ_of(state_q);
  assign acc       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;

  // State register; reset always lands in EMPTY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and load-enable decode. A flush overrides everything that
  // the handshakes would have done: any same-cycle accept is dropped, while
  // a same-cycle dequeue has already been taken by the downstream stage.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;

    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d   = ST_BUSY;
          load_main = 1'b1;
        end
      end
      ST_BUSY: begin
        if (acc && deq) begin
          load_main = 1'b1;
        end else if (deq) begin
          state_d = ST_EMPTY;
        end else if (acc && (SKID != 0)) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end
      end
      ST_FULL: begin
        if (deq) begin
          state_d        = ST_BUSY;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: begin
        // Unreachable encoding recovers exactly like EMPTY.
        state_d = ST_EMPTY;
        if (acc) begin
          state_d   = ST_BUSY;
          load_main = 1'b1;
        end
      end
    endcase

    if (flush) begin
      state_d        = ST_EMPTY;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // With a skid entry, in_ready is registered from the next state so that
  // out_ready never reaches in_ready combinationally. Without one, the
  // stage can only accept when its single entry is empty or leaving.
  generate
    if (SKID != 0) begin : g_skid_ready
      logic in_ready_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= (state_d != ST_FULL);
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_comb_ready
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid
// buffer and synchronous flush. Sits between npc pipeline stages.
//
// Parameters:
//   WIDTH      payload width
//   RESET_VAL  payload value after reset
//   SKID       1: two entries, registered in_ready; 0: one entry
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   flush                squash all held entries
//   in_valid/in_ready    upstream handshake, in_data payload
//   out_valid/out_ready  downstream handshake, out_data payload (main entry)
//   occ                  entries held (0..2)
module pipe_stage_reg
  import npc_pipe_pkg::*;
#(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  parameter int unsigned          SKID      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  logic             load_main;
  logic             main_from_skid;
  logic             load_skid;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  pipe_stage_ctrl #(
    .SKID (SKID)
  ) u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .occ            (occ),
    .load_main      (load_main),
    .main_from_skid (main_from_skid),
    .load_skid      (load_skid)
  );

  // Main register only changes on an accept or a skid->main refill, which
  // keeps out_data bit-stable while the downstream stalls. Flush leaves the
  // payload alone; only the control state is squashed.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= RESET_VAL;
    end else if (load_main) begin
      main_q <= main_from_skid ? skid_q : in_data;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      always_ff @(posedge clk) begin
        if (rst) begin
          skid_q <= RESET_VAL;
        end else if (load_skid) begin
          skid_q <= in_data;
        end
      end
    end else begin : g_no_skid
      // The controller never raises load_skid in this configuration.
      logic unused_load_skid;
      assign unused_load_skid = load_skid;
      assign skid_q           = RESET_VAL;
    end
  endgenerate

  assign out_data = main_q;

endmodule
